// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: parallel-to-serial front end for the pattern detector.
// Words arrive over valid/ready and leave one bit per clock on x. A one-word
// holding buffer lets back-to-back words stream with no idle gap.
module serial_bit_feeder #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             x,
  output logic             x_valid,
  output logic             x_last,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 2);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [WIDTH-1:0] hold_buf;
  logic             hold_full;
  logic [CW-1:0]    cnt;
  logic             xfer;

  // Bit that leaves the word first, and the word with that bit consumed.
  function automatic logic head(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? d[WIDTH-1] : d[0];
  endfunction

  function automatic logic [WIDTH-1:0] tail(input logic [WIDTH-1:0] d);
    return MSB_FIRST ? {d[WIDTH-2:0], 1'b0} : {1'b0, d[WIDTH-1:1]};
  endfunction

  // Ready only depends on the buffer; suppressed while reset is asserted.
  assign in_ready = !hold_full && !rst;
  assign xfer     = in_valid && in_ready;
  assign busy     = (state == SHIFT) || hold_full;

  // Shifter FSM: loads words, emits one bit per cycle, refills at word boundary.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      hold_buf  <= '0;
      hold_full <= 1'b0;
      cnt       <= '0;
      x         <= IDLE_BIT;
      x_valid   <= 1'b0;
      x_last    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (xfer) begin
            state   <= SHIFT;
            x       <= head(in_data);
            shreg   <= tail(in_data);
            cnt     <= '0;
            x_valid <= 1'b1;
            x_last  <= 1'b0;
          end else begin
            x       <= IDLE_BIT;
            x_valid <= 1'b0;
            x_last  <= 1'b0;
          end
        end
        SHIFT: begin
          if (cnt == CNT_LAST) begin
            if (hold_full) begin
              x         <= head(hold_buf);
              shreg     <= tail(hold_buf);
              hold_full <= 1'b0;
              cnt       <= '0;
              x_valid   <= 1'b1;
              x_last    <= 1'b0;
            end else if (xfer) begin
              x       <= head(in_data);
              shreg   <= tail(in_data);
              cnt     <= '0;
              x_valid <= 1'b1;
              x_last  <= 1'b0;
            end else begin
              state   <= IDLE;
              cnt     <= '0;
              x       <= IDLE_BIT;
              x_valid <= 1'b0;
              x_last  <= 1'b0;
            end
          end else begin
            x      <= head(shreg);
            shreg  <= tail(shreg);
            cnt    <= cnt + 1'b1;
            x_last <= (cnt == CNT_PENULT);
            if (xfer) begin
              hold_buf  <= in_data;
              hold_full <= 1'b1;
            end
          end
        end
        default: begin
          state     <= IDLE;
          hold_full <= 1'b0;
          cnt       <= '0;
          x         <= IDLE_BIT;
          x_valid   <= 1'b0;
          x_last    <= 1'b0;
        end
      endcase
    end
  end

endmodule
